// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seqdet_pkg;

    localparam int unsigned PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH_FILL  = 2'd0,
        PH_ARMED = 2'd1,
        PH_HIT   = 2'd2
    } phase_t;

    // Bits needed to count 0..pat_w window fill.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_window.sv
// Serial shift window with saturating fill count; flush wins over a new bit.
module seqdet_window
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned FILL_W = fill_width(PAT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              x,
    input  logic              flush,
    input  logic              consume,
    output logic [PAT_W-1:0]  hist,
    output logic [FILL_W-1:0] fill,
    output logic [PAT_W-1:0]  next_hist_c,
    output logic [FILL_W-1:0] next_fill_c
);

    always_comb begin
        next_hist_c = {hist[PAT_W-2:0], x};
        next_fill_c = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    end

    // A consumed (non-overlapping) match leaves no bits for the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= next_hist_c;
            fill <= consume ? '0 : next_fill_c;
        end
    end

endmodule

// File: rtl/seqdet_param.sv
// Programmable-pattern serial detector: config latch, phase FSM, match counter.
module seqdet_param
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          x,
    input  logic [PAT_W-1:0]              cfg_pattern,
    input  logic                          cfg_overlap,
    input  logic                          cfg_load,
    input  logic                          cnt_clr,
    output logic                          z,
    output logic [CNT_W-1:0]              match_count,
    output logic [fill_width(PAT_W)-1:0]  state_out,
    output logic [PHASE_W-1:0]            phase_out
);

    localparam int unsigned FILL_W = fill_width(PAT_W);

    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] nf;
    logic              bit_c;
    logic              hit_c;
    phase_t            phase;
    phase_t            phase_next;
    logic [CNT_W-1:0]  cnt_next;

    assign bit_c = en & ~cfg_load;
    assign hit_c = bit_c && (nf == FILL_W'(PAT_W)) && (nh == pat_q);

    seqdet_window #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .x           (x),
        .flush       (cfg_load),
        .consume     (hit_c & ~ovl_q),
        .hist        (hist),
        .fill        (fill),
        .next_hist_c (nh),
        .next_fill_c (nf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            ovl_q <= 1'b0;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            ovl_q <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= PH_FILL;
            z           <= 1'b0;
            match_count <= '0;
        end else begin
            phase       <= phase_next;
            z           <= (phase_next == PH_HIT);
            match_count <= cnt_next;
        end
    end

    always_comb begin
        phase_next = phase;
        cnt_next   = match_count;

        if (cfg_load) begin
            phase_next = PH_FILL;
        end else if (en) begin
            if (hit_c) begin
                phase_next = PH_HIT;
            end else if (nf == FILL_W'(PAT_W)) begin
                phase_next = PH_ARMED;
            end else begin
                phase_next = PH_FILL;
            end
        end else if (phase == PH_HIT) begin
            phase_next = ovl_q ? PH_ARMED : PH_FILL;
        end

        // A clear coinciding with a hit still counts that hit.
        if (hit_c) begin
            if (cnt_clr) begin
                cnt_next = CNT_W'(1);
            end else if (!(&match_count)) begin
                cnt_next = match_count + CNT_W'(1);
            end
        end else if (cnt_clr) begin
            cnt_next = '0;
        end
    end

    assign state_out = fill;
    assign phase_out = phase;

endmodule

// File: tb/tb_seqdet_param.sv
// Scoreboard bench for seqdet_param: 4-bit/8-bit-counter and 8-bit/2-bit-counter instances.
module tb_seqdet_param;

    typedef struct packed {
        logic       z;
        logic [7:0] cnt;
        logic [2:0] st;
        logic [1:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, x = 1'b0, cfg_overlap = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
    logic [3:0] cfg_pattern = 4'h0;
    logic       z;
    logic [7:0] match_count;
    logic [2:0] state_out;
    logic [1:0] phase_out;

    logic       en8 = 1'b0, x8 = 1'b0, ovl8 = 1'b0, load8 = 1'b0, clr8 = 1'b0;
    logic [7:0] pat8 = 8'h00;
    logic       z8;
    logic [1:0] cnt8;
    logic [3:0] st8;
    logic [1:0] ph8;

    int checks = 0;
    int failures = 0;

    exp_t       exp_q[$];
    logic [2:0] exp8_q[$];

    logic [3:0] m_pat, m_hist;
    logic       m_ovl;
    int         m_fill;
    logic [1:0] m_phase;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    seqdet_param #(.PAT_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .x(x),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .cfg_load(cfg_load), .cnt_clr(cnt_clr),
        .z(z), .match_count(match_count), .state_out(state_out), .phase_out(phase_out)
    );

    seqdet_param #(.PAT_W(8), .CNT_W(2)) u_dut8 (
        .clk(clk), .reset(reset), .en(en8), .x(x8),
        .cfg_pattern(pat8), .cfg_overlap(ovl8),
        .cfg_load(load8), .cnt_clr(clr8),
        .z(z8), .match_count(cnt8), .state_out(st8), .phase_out(ph8)
    );

    task automatic model_reset();
        m_pat = 4'h0; m_hist = 4'h0; m_ovl = 1'b0; m_fill = 0; m_phase = 2'd0; m_cnt = 8'h00;
    endtask

    // Drive one edge on the 4-bit instance and push what the spec says must follow.
    task automatic step(input logic e, input logic xb, input logic ld, input logic cl);
        logic [3:0] nh;
        int         nf;
        logic       hit;
        en = e; x = xb; cfg_load = ld; cnt_clr = cl;
        hit = 1'b0;
        if (ld) begin
            m_pat = cfg_pattern; m_ovl = cfg_overlap; m_hist = 4'h0; m_fill = 0; m_phase = 2'd0;
        end else if (e) begin
            nh = {m_hist[2:0], xb};
            nf = (m_fill + 1 > 4) ? 4 : m_fill + 1;
            hit = (nf == 4) && (nh == m_pat);
            m_hist = nh;
            if (hit) begin
                m_phase = 2'd2;
                m_fill = m_ovl ? 4 : 0;
            end else begin
                m_phase = (nf == 4) ? 2'd1 : 2'd0;
                m_fill = nf;
            end
        end else if (m_phase == 2'd2) begin
            m_phase = m_ovl ? 2'd1 : 2'd0;
        end
        if (hit) m_cnt = cl ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : 8'(m_cnt + 8'd1));
        else if (cl) m_cnt = 8'd0;
        exp_q.push_back({(m_phase == 2'd2), m_cnt, 3'(m_fill), m_phase});
        @(posedge clk); #1;
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic step8(input logic e, input logic xb, input logic ld, input logic cl);
        en8 = e; x8 = xb; load8 = ld; clr8 = cl;
        @(posedge clk); #1;
        en8 = 1'b0; load8 = 1'b0; clr8 = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        checks++;
        if ({z, match_count, state_out, phase_out} !== 14'h0) begin
            failures++;
            $display("FAIL reset4 got=%h exp=0", {z, match_count, state_out, phase_out});
        end
        checks++;
        if ({z8, cnt8, st8, ph8} !== 9'h0) begin
            failures++;
            $display("FAIL reset8 got=%h exp=0", {z8, cnt8, st8, ph8});
        end
    endtask

    task automatic load_cfg(input logic [3:0] p, input logic ov, input logic cl, input string name);
        exp_t e;
        cfg_pattern = p; cfg_overlap = ov;
        step(1'b1, 1'b1, 1'b1, cl);
        e = exp_q.pop_front();
        checks++;
        if ({z, match_count, state_out, phase_out} !== e) begin
            failures++;
            $display("FAIL %s_load got=%h exp=%h", name, {z, match_count, state_out, phase_out}, e);
        end
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[n-1-i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({z, match_count, state_out, phase_out} !== e) begin
                failures++;
                $display("FAIL %s bit%0d got=%h exp=%h", name, i, {z, match_count, state_out, phase_out}, e);
            end
        end
    endtask

    task automatic test_no_match();
        load_cfg(4'b1011, 1'b0, 1'b1, "nomatch");
        run_bits(16'b11001, 5, "nomatch");
        checks++;
        if (match_count !== 8'd0 || state_out !== 3'd4) begin
            failures++;
            $display("FAIL nomatch_end cnt=%0d st=%0d exp cnt=0 st=4", match_count, state_out);
        end
    endtask

    task automatic test_single_and_back_to_back();
        exp_t e;
        load_cfg(4'b1011, 1'b0, 1'b1, "single");
        run_bits(16'b1011, 4, "single");
        checks++;
        if (z !== 1'b1 || match_count !== 8'd1) begin
            failures++;
            $display("FAIL single_hit z=%b cnt=%0d exp z=1 cnt=1", z, match_count);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({z, match_count, state_out, phase_out} !== e || z !== 1'b0) begin
            failures++;
            $display("FAIL single_fall got=%h exp=%h", {z, match_count, state_out, phase_out}, e);
        end
        run_bits(16'b10111011, 8, "b2b");
        checks++;
        if (match_count !== 8'd3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", match_count);
        end
    endtask

    task automatic test_overlap();
        load_cfg(4'b1011, 1'b1, 1'b1, "ovl");
        run_bits(16'b1011011, 7, "ovl");
        checks++;
        if (match_count !== 8'd2) begin
            failures++;
            $display("FAIL ovl_count got=%0d exp=2", match_count);
        end
        load_cfg(4'b1011, 1'b0, 1'b1, "novl");
        run_bits(16'b1011011, 7, "novl");
        checks++;
        if (match_count !== 8'd1) begin
            failures++;
            $display("FAIL novl_count got=%0d exp=1", match_count);
        end
    endtask

    task automatic test_overlap_run();
        load_cfg(4'b1111, 1'b1, 1'b1, "ones");
        run_bits(16'b111111, 6, "ones");
        checks++;
        if (match_count !== 8'd3 || z !== 1'b1 || phase_out !== 2'd2) begin
            failures++;
            $display("FAIL ones_end cnt=%0d z=%b ph=%0d exp cnt=3 z=1 ph=2", match_count, z, phase_out);
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        load_cfg(4'b1011, 1'b0, 1'b1, "ldpri");
        run_bits(16'b101, 3, "ldpri");
        step(1'b1, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({z, match_count, state_out, phase_out} !== e || z !== 1'b0 || state_out !== 3'd0) begin
            failures++;
            $display("FAIL ldpri_edge got=%h exp=%h", {z, match_count, state_out, phase_out}, e);
        end
    endtask

    task automatic test_reset_mid();
        load_cfg(4'b1011, 1'b0, 1'b1, "rstmid");
        run_bits(16'b10, 2, "rstmid");
        #1 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (z !== 1'b0 || state_out !== 3'd0 || match_count !== 8'd0 || phase_out !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_async z=%b st=%0d cnt=%0d ph=%0d exp all 0", z, state_out, match_count, phase_out);
        end
        #1 reset = 1'b0;
        // Pattern reverts to 0000, so only four zeros after the fill completes should hit.
        run_bits(16'b110000, 6, "rstpat");
        checks++;
        if (match_count !== 8'd1) begin
            failures++;
            $display("FAIL rstpat_count got=%0d exp=1", match_count);
        end
    endtask

    task automatic test_wide_gaps();
        logic [7:0] p;
        logic [2:0] e;
        p = 8'hA5;
        pat8 = p; ovl8 = 1'b0;
        step8(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp8_q.push_back({(i == 7), (i == 7) ? 2'd1 : 2'd0});
            step8(1'b1, p[7-i], 1'b0, 1'b0);
            e = exp8_q.pop_front();
            checks++;
            if ({z8, cnt8} !== e) begin
                failures++;
                $display("FAIL gaps bit%0d got=%h exp=%h", i, {z8, cnt8}, e);
            end
            for (int k = 0; k < 3; k++) begin
                exp8_q.push_back({1'b0, (i == 7) ? 2'd1 : 2'd0});
                step8(1'b0, 1'b0, 1'b0, 1'b0);
                e = exp8_q.pop_front();
                checks++;
                if ({z8, cnt8} !== e) begin
                    failures++;
                    $display("FAIL gaps idle%0d_%0d got=%h exp=%h", i, k, {z8, cnt8}, e);
                end
            end
        end
        checks++;
        if (st8 !== 4'd0 || ph8 !== 2'd0) begin
            failures++;
            $display("FAIL gaps_end st=%0d ph=%0d exp st=0 ph=0", st8, ph8);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] e;
        int         ec;
        pat8 = 8'hFF; ovl8 = 1'b1;
        step8(1'b0, 1'b0, 1'b1, 1'b1);
        ec = 0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 7 && ec < 3) ec++;
            exp8_q.push_back({(i >= 7), 2'(ec)});
            step8(1'b1, 1'b1, 1'b0, 1'b0);
            e = exp8_q.pop_front();
            checks++;
            if ({z8, cnt8} !== e) begin
                failures++;
                $display("FAIL sat bit%0d got=%h exp=%h", i, {z8, cnt8}, e);
            end
        end
        exp8_q.push_back({1'b1, 2'd1});
        step8(1'b1, 1'b1, 1'b0, 1'b1);
        e = exp8_q.pop_front();
        checks++;
        if ({z8, cnt8} !== e) begin
            failures++;
            $display("FAIL clr_with_hit got=%h exp=%h", {z8, cnt8}, e);
        end
        exp8_q.push_back({1'b0, 2'd0});
        step8(1'b0, 1'b0, 1'b0, 1'b1);
        e = exp8_q.pop_front();
        checks++;
        if ({z8, cnt8, ph8} !== {e, 2'd1}) begin
            failures++;
            $display("FAIL clr_no_hit got=%h exp=%h", {z8, cnt8, ph8}, {e, 2'd1});
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        test_no_match();
        test_single_and_back_to_back();
        test_overlap();
        test_overlap_run();
        test_load_priority();
        test_wide_gaps();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seqdet_param.md
# seqdet_param

Parametrised serial bit-sequence detector, successor to the fixed 4-bit `fsmseq` detector. It matches a runtime-programmable pattern of `PAT_W` bits on a gated serial input and supports selectable overlapping or non-overlapping detection. Each match produces a one-cycle Moore pulse and increments a saturating match counter. It sits between a serial data source and lab-board LEDs or counters, and exposes its window fill level and phase for debug.

## Interface
- `PAT_W`, default 4: pattern length in bits, legal range 2..16.
- `CNT_W`, default 8: match counter width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `en`  in  1: bit-valid qualifier. `x` is sampled only on edges where `en`=1.
- `x`  in  1: serial data bit.
- `cfg_pattern`  in  `PAT_W`: pattern. Bit `PAT_W-1` is the first bit received.
- `cfg_overlap`  in  1: 1 = overlapping detection, 0 = non-overlapping.
- `cfg_load`  in  1: one-cycle pulse. Latches `cfg_pattern` and `cfg_overlap`, and flushes the window.
- `cnt_clr`  in  1: one-cycle pulse. Clears `match_count`.
- `z`  out  1: match pulse.
- `match_count`  out  `CNT_W`: number of matches, saturating at all-ones.
- `state_out`  out  `$clog2(PAT_W+1)`: window fill count, range 0..`PAT_W`.
- `phase_out`  out  2: FSM phase (FILL=0, ARMED=1, HIT=2).

## Operation
- Registers:
  - `pat_q` and `ovl_q`: latched configuration.
  - `hist`: `PAT_W`-bit window. New bit enters at bit 0; bit `PAT_W-1` is the oldest.
  - `fill`: bits in the window since the last flush.
  - `phase`.
  - `match_count`.
- Reset values:
  - `pat_q`, `ovl_q`, `hist`, `fill`: 0.
  - `phase`: FILL.
  - `z`, `match_count`, `state_out`, `phase_out`: 0.
- Only `cfg_load` changes the configuration. The pattern is never taken live from `cfg_pattern`.
- On an edge with `en`=1 (and no `cfg_load`):
  - `nh = {hist[PAT_W-2:0], x}`.
  - `nf = min(fill+1, PAT_W)`.
  - `hit = (nf==PAT_W) && (nh==pat_q)`.
  - `hist <= nh`.
- Phase transitions on an edge with `en`=1:
  - `hit`: go to HIT. If `ovl_q`=0, also `fill <= 0` (window fully consumed). If `ovl_q`=1, `fill <= PAT_W`.
  - No hit, `nf==PAT_W`: go to ARMED, `fill <= PAT_W`.
  - No hit, `nf<PAT_W`: go to FILL, `fill <= nf`.
- Phase transitions on an edge with `en`=0:
  - HIT goes to ARMED if `ovl_q`=1, otherwise to FILL.
  - FILL and ARMED hold.
  - `hist` and `fill` hold.
- Outputs:
  - `z = (phase==HIT)`.
  - `state_out = fill`.
  - `phase_out = phase`.
- Match counter:
  - Increments on every transition into HIT.
  - Holds at `2^CNT_W-1` once it saturates.
- Priority rules:
  - `cfg_load` beats `en`: the bit on that edge is discarded; `hist`/`fill` become 0; phase becomes FILL; `z` becomes 0 on that edge.
  - `cnt_clr` together with a hit on the same edge: `match_count` becomes 1.
  - `cnt_clr` without a hit: `match_count` becomes 0.
- Non-overlap with consecutive matches: the next match needs `PAT_W` fresh bits. No bit is reused.
- Overlap: HIT can follow HIT on consecutive `en` edges, e.g. pattern 1111 with `x`=1 held.

## Timing
- Latency:
  - `z` rises on the rising edge that samples the final pattern bit, i.e. 0 cycles after sampling; it is a registered Moore output.
  - `z` falls on the next edge unless that edge produces another hit.
- With `en`=1 every cycle and overlap on, `z` can be high on consecutive cycles. Each such cycle is a distinct match and is counted.
- Reset asserted mid-operation:
  - All outputs go to their reset values asynchronously, with no wait for an edge.
  - The configuration returns to pattern 0, non-overlap. `cfg_load` must be re-issued after reset.
- Earliest possible match: the `PAT_W`-th `en` edge after reset or `cfg_load`.

## Structure
- Package `seqdet_pkg`:
  - Phase encoding constants (FILL/ARMED/HIT = 0/1/2) and the phase typedef.
  - Width function for `state_out`.
- Sub-module `seqdet_window`: holds `hist` and `fill`, with shift, saturate and flush, plus inputs `en`, `x`, `flush`. The top level holds the configuration, the phase FSM and the counter.
- Top-level target: 150-250 lines of RTL.

## Test plan
- Pattern 1011, non-overlap; `x`=1,1,0,0,1 with `en`=1 -> `z` never 1, `match_count`=0, `state_out` saturates at 4.
- Pattern 1011, non-overlap; 1,0,1,1 -> `z`=1 for exactly one cycle after the 4th bit; count=1. Then 1,0,1,1,1,0,1,1 -> two more pulses, count=3.
- Pattern 1011, overlap; 1,0,1,1,0,1,1 -> pulses after bits 4 and 7, count=2. The same stream with non-overlap -> only one pulse.
- `PAT_W`=8, pattern 0xA5, with `en` gaps of 3 idle cycles between bits -> a single pulse after the 8th valid bit, and `z` lasts one cycle despite the idle cycles. Pattern 1111, overlap, with 6 ones -> 3 consecutive pulses.
- `CNT_W`=2 with 5 matches -> `match_count`=3 (saturated). `cnt_clr` on the same edge as a hit -> 1.
- `reset` asserted between bits 2 and 3 of a match -> `state_out`=0 and `z`=0 without waiting for a clock edge, and no match occurs. `cfg_load` on a completing edge -> `z`=0, `state_out`=0.
